mul_compressor_pipe: RTL and testbench
======================================

Name: mul_compressor_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 combinational GPC compressor tree.
- Generates partial products for a WIDTH x WIDTH multiply, unsigned or two's-complement selectable per operation.
- Reduces the partial-product heap through column compressors with STAGES register boundaries, then resolves it with a final carry-propagate adder.
- Sits between operand producers and consumers in the multiplier datapath, using a valid/ready stream on both sides.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- STAGES, 4, number of registered reduction segments; legal range 1..8.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tc  input  1  1 = signed two's-complement multiply, 0 = unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_product  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the operation in out_product.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset state (rst_n=0 at a clock edge): all stage valid bits, out_valid, out_product and out_tag clear to 0. Internal heap registers need no reset.
- Pipeline structure:
  - LAT = STAGES+1 register slots.
  - Slot 0 captures the partial-product heap, tc and tag.
  - Slots 1..STAGES-1 each hold the heap after one combinational reduction segment.
  - The last slot holds out_product and out_tag.
- Reduction:
  - Total reduction depth is divided as evenly as possible across the STAGES segments; earlier segments take the larger share.
  - The heap at the input of the final adder has column height <= 2.
  - Every column height stays within 2*WIDTH bits; no carry out of bit 2*WIDTH-1 is kept (the result is exact for both modes).
- Partial products:
  - Unsigned: pp[i][j] = a[j] & b[i].
  - Signed: Baugh-Wooley. Invert the pp terms involving exactly one MSB; add constant 1 at columns WIDTH and 2*WIDTH-1.
  - Result equals the mathematical product modulo 2^(2*WIDTH).
- Stall rule: adv = !out_valid | out_ready.
  - When adv=1, every slot loads from its predecessor and the valid bits shift.
  - When adv=0, all slots hold.
  - Bubbles are not collapsed.
- Input handshake:
  - in_ready = adv; it is combinational from out_valid and out_ready.
  - Accept = in_valid & in_ready. Slot 0 valid loads Accept.
- Latency and throughput:
  - With out_ready held at 1, a result accepted at cycle N appears with out_valid=1 at cycle N+LAT.
  - Throughput is 1 per cycle.
- Output handshake:
  - out_valid, out_product and out_tag stay stable while out_valid=1 & out_ready=0.
  - When out_ready=1 and no new result arrives, out_valid drops the next cycle. out_product holds its last value and is don't-care while out_valid=0.
- Simultaneous events:
  - On a cycle with out_valid & out_ready & Accept, the output updates to the next slot's result; the new operand enters slot 0.
  - No operation is dropped or duplicated.
- Reset mid-operation: all in-flight operations are discarded. out_valid=0 the cycle after reset, and in_ready=1 once rst_n is high.
- in_tc and in_tag are sampled only on Accept and travel with their operation.
- Elaboration check: a WIDTH or STAGES outside its legal range raises an elaboration-time error.

Test Plan:
- Unsigned max: WIDTH=8, STAGES=4, in_tc=0, a=255, b=255, tag=3, out_ready=1 -> out_product=0xFE01 and out_tag=3, with out_valid exactly 5 cycles after accept.
- Signed corners: in_tc=1, issued back-to-back.
  - a=0x80, b=0x80 -> 0x4000.
  - a=0x80, b=0x7F -> 0xC080.
  - a=0xFF, b=0x01 -> 0xFFFF.
  - Results arrive on consecutive cycles in order.
- Backpressure: stream 8 operations, with out_ready=0 for 3 cycles while out_valid=1.
  - in_ready is 0 during the stall.
  - out_product and out_tag stay stable.
  - All 8 results arrive in order with the correct tags.
- Reset mid-flight: 3 operations accepted, rst_n=0 for 1 cycle -> out_valid stays 0. A new op 7*9 unsigned then returns 63 after 5 cycles.
- Exhaustive: all 65536 8-bit operand pairs in both modes with random out_ready toggling -> matches the reference model. Then WIDTH=13, STAGES=1 and WIDTH=32, STAGES=8, each with 10^5 random pairs -> matches; latency = STAGES+1.

Source files
------------

// File: rtl/mul_compressor_pipe.sv
// mul_compressor_pipe
// Pipelined WIDTH x WIDTH multiplier built from a partial-product heap,
// carry-save (3:2) reduction split over STAGES register segments and a final
// carry-propagate adder. Unsigned or two's-complement per operation.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block accepts operands this cycle (= !out_valid | out_ready)
//   in_a, in_b   multiplicand / multiplier, WIDTH bits
//   in_tc        1 = signed two's-complement, 0 = unsigned
//   in_tag       sideband tag returned with the result
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_product  2*WIDTH-bit product (modulo 2^(2*WIDTH))
//   out_tag      tag of the operation in out_product
//
// Latency is STAGES+1 cycles; throughput is one operation per cycle.
module mul_compressor_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_tc,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = 2 * WIDTH;
    // One row per multiplier bit plus one row for the Baugh-Wooley constants.
    localparam int NR = WIDTH + 1;

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $error("mul_compressor_pipe: WIDTH must be in 2..32");
    end
    if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
        $error("mul_compressor_pipe: STAGES must be in 1..8");
    end

    typedef logic [NR-1:0][PW-1:0] heap_t;

    // Row count after one 3:2 layer: each full group of three rows becomes two.
    function automatic int rows_after(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Number of 3:2 layers needed to bring n rows down to at most two.
    function automatic int depth_of(input int n);
        int r;
        int d;
        r = n;
        d = 0;
        while (r > 2) begin
            r = rows_after(r);
            d++;
        end
        return d;
    endfunction

    localparam int DEPTH = depth_of(NR);
    localparam int BASE  = DEPTH / STAGES;
    localparam int EXTRA = DEPTH % STAGES;

    // Earlier segments absorb the remainder layers.
    function automatic int seg_len(input int s);
        return BASE + ((s < EXTRA) ? 1 : 0);
    endfunction

    function automatic int seg_start(input int s);
        return s * BASE + ((s < EXTRA) ? s : EXTRA);
    endfunction

    function automatic int rows_at(input int layers);
        int r;
        r = NR;
        for (int k = 0; k < layers; k++) begin
            r = rows_after(r);
        end
        return r;
    endfunction

    // One carry-save layer over the first n rows; unused rows are zero.
    // Carries shift left inside PW bits, so overflow past the MSB is dropped.
    function automatic heap_t csa_layer(input heap_t h, input int n);
        heap_t          o;
        logic [PW-1:0]  maj;
        int             g3;
        o  = '0;
        g3 = n / 3;
        for (int g = 0; g < NR / 3; g++) begin
            if (g < g3) begin
                maj        = (h[3*g] & h[3*g+1]) | (h[3*g] & h[3*g+2]) | (h[3*g+1] & h[3*g+2]);
                o[2*g]     = h[3*g] ^ h[3*g+1] ^ h[3*g+2];
                o[2*g+1]   = {maj[PW-2:0], 1'b0};
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k < (n % 3)) begin
                o[2*g3+k] = h[3*g3+k];
            end
        end
        return o;
    endfunction

    // Apply nl layers starting from a heap of n0 rows.
    function automatic heap_t seg_reduce(input heap_t h, input int n0, input int nl);
        heap_t x;
        int    n;
        x = h;
        n = n0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < nl) begin
                x = csa_layer(x, n);
                n = rows_after(n);
            end
        end
        return x;
    endfunction

    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic                 w_adv;
    logic                 w_accept;
    heap_t                w_heap0;
    heap_t                w_seg [STAGES];
    logic [PW-1:0]        w_sum;

    heap_t                r_heap [STAGES];
    logic [TAG_W-1:0]     r_tag  [STAGES];
    logic [STAGES-1:0]    r_vld;
    logic                 r_out_valid;
    logic [PW-1:0]        r_out_product;
    logic [TAG_W-1:0]     r_out_tag;

    assign w_adv     = !r_out_valid | out_ready;
    assign w_accept  = in_valid & w_adv;
    assign in_ready  = w_adv;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_tag     = r_out_tag;

    // Partial-product heap; in signed mode terms with exactly one MSB are inverted.
    always_comb begin
        w_heap0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_heap0[i][i+j] = (in_a[j] & in_b[i]) ^ (in_tc & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (in_tc) begin
            w_heap0[NR-1] = BW_CONST;
        end else begin
            w_heap0[NR-1] = '0;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_seg
        localparam int SEG_ROWS = rows_at(seg_start(s));
        localparam int SEG_LEN  = seg_len(s);
        assign w_seg[s] = seg_reduce(r_heap[s], SEG_ROWS, SEG_LEN);
    end

    // Final carry-propagate add; rows past the second are zero after reduction.
    always_comb begin
        w_sum = '0;
        for (int r = 0; r < NR; r++) begin
            w_sum = w_sum + w_seg[STAGES-1][r];
        end
    end

    // Heap and tag slots advance together; bubbles carry don't-care data.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_heap[0] <= w_heap0;
            r_tag[0]  <= in_tag;
            for (int s = 1; s < STAGES; s++) begin
                r_heap[s] <= w_seg[s-1];
                r_tag[s]  <= r_tag[s-1];
            end
        end
    end

    // Valid chain and output slot; the product only updates for a real result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld         <= '0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_tag     <= '0;
        end else if (w_adv) begin
            r_vld[0] <= w_accept;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
            r_out_valid <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_out_product <= w_sum;
                r_out_tag     <= r_tag[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_mul_compressor_pipe.sv
// Directed bench for mul_compressor_pipe (WIDTH=8, STAGES=4, TAG_W=4).
module tb_mul_compressor_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_tc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic [3:0]  out_tag;

    mul_compressor_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tc(in_tc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [3:0]  tag;
    } exp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_n   = 0;
    bit    rnd_ready = 1'b0;
    exp_t  pend;
    exp_t  sbq[$];
    int    arr_cyc[$];
    logic [7:0] cv [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic tc);
        longint     x;
        longint     y;
        logic [63:0] p;
        if (tc) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = 64'(x * y);
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score outputs, return aligned to posedge+1.
    task automatic cyc(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) sbq.push_back(pend);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_out observed=%0h expected=none", out_product);
            end else begin
                e = sbq.pop_front();
                chk("product", 32'(out_product), 32'(e.prod));
                chk("tag", 32'(out_tag), 32'(e.tag));
                arr_cyc.push_back(cyc_n);
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic tc,
                        input logic [3:0] tag, input logic [15:0] exp);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tc = tc;
        in_tag = tag;
        pend.prod = exp;
        pend.tag  = tag;
        for (int k = 0; k < 200; k++) begin
            if (!acc) cyc(acc);
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $error("FAIL accept_timeout observed=0 expected=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc(acc);
    endtask

    // Single op on an empty pipe: latency, value, tag, then out_valid drop.
    task automatic lat_check(input logic [7:0] a, input logic [7:0] b, input logic tc,
                             input logic [3:0] tag, input logic [15:0] exp);
        int lat;
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tc = tc;
        in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (lat == 0) begin
                @(negedge clk);
                if (out_valid) lat = k;
            end
        end
        chk("latency", 32'(lat), 32'd5);
        chk("lat_product", 32'(out_product), 32'(exp));
        chk("lat_tag", 32'(out_tag), 32'(tag));
        @(negedge clk);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("product_hold", 32'(out_product), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rt;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_tc = 1'b0;
        in_tag = 4'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(out_product), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unsigned max with latency
        lat_check(8'd255, 8'd255, 1'b0, 4'd3, 16'hFE01);

        // Signed corners back-to-back
        arr_cyc.delete();
        send(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
        send(8'h80, 8'h7F, 1'b1, 4'd2, 16'hC080);
        send(8'hFF, 8'h01, 1'b1, 4'd4, 16'hFFFF);
        idle(8);
        chk("signed_count", 32'(arr_cyc.size()), 32'd3);
        if (arr_cyc.size() == 3) begin
            chk("signed_consec0", 32'(arr_cyc[1] - arr_cyc[0]), 32'd1);
            chk("signed_consec1", 32'(arr_cyc[2] - arr_cyc[1]), 32'd1);
        end
        chk("signed_drained", 32'(sbq.size()), 32'd0);

        // Backpressure: 3-cycle stall with the pipe full
        for (int i = 0; i < 6; i++) begin
            ra = 8'(i * 37 + 11);
            rb = 8'(250 - i * 23);
            send(ra, rb, 1'b0, 4'(i + 8), ref_mul(ra, rb, 1'b0));
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_product", 32'(out_product), 32'(sbq[0].prod));
            chk("stall_tag", 32'(out_tag), 32'(sbq[0].tag));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 6; i < 8; i++) begin
            ra = 8'(i * 37 + 11);
            rb = 8'(250 - i * 23);
            send(ra, rb, 1'b0, 4'(i + 8), ref_mul(ra, rb, 1'b0));
        end
        idle(12);
        chk("bp_drained", 32'(sbq.size()), 32'd0);

        // Reset with three operations in flight
        send(8'd3, 8'd5, 1'b1, 4'd1, ref_mul(8'd3, 8'd5, 1'b1));
        send(8'd200, 8'd100, 1'b1, 4'd2, ref_mul(8'd200, 8'd100, 1'b1));
        send(8'd17, 8'd19, 1'b0, 4'd3, ref_mul(8'd17, 8'd19, 1'b0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        lat_check(8'd7, 8'd9, 1'b0, 4'd5, 16'd63);

        // Corner operand sweep in both modes with random backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    send(cv[i], cv[j], 1'(t), 4'(i * 5 + j), ref_mul(cv[i], cv[j], 1'(t)));
                end
            end
        end
        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rt = 1'($urandom_range(0, 1));
            send(ra, rb, rt, 4'(k), ref_mul(ra, rb, rt));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(20);
        chk("final_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
